// File: rtl/readout_sequencer.sv
// readout_sequencer
// Walks the enabled digitizer channels in ascending order after an
// end-of-spill event and a programmable delay. For each channel it raises the
// channel trigger, issues the programmed number of read strobes (paced by the
// downstream ready), then waits for the channel's readout-done or a timeout.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   eos_i          end-of-spill; a rising edge starts a sequence from IDLE
//   chan_en_i      channels to read, latched at start
//   offset_i       cycles spent in DELAY before the first channel, latched at start
//   how_many_i     read requests per channel, latched at start
//   zynq_ready_i   downstream accepts a word this cycle
//   rodone_ni      per-channel readout done, active low
//   trigger_o      one-hot trigger of the active channel
//   rd_request_o   one-hot read strobe to the active channel
//   sel_o          index of the active channel
//   zynq_rd_en_o   high while a sequence is in progress
//   done_o         one-cycle pulse at sequence end
//   err_mask_o     sticky per-channel timeout flags, cleared at next start
module readout_sequencer #(
  parameter int CHAN  = 8,
  parameter int CNT_W = 12,
  parameter int OFF_W = 16,
  parameter int TMO   = 4096,
  localparam int SEL_W  = (CHAN > 1) ? $clog2(CHAN) : 1,
  localparam int TCNT_W = $clog2(TMO) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              eos_i,
  input  logic [CHAN-1:0]   chan_en_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [CNT_W-1:0]  how_many_i,
  input  logic              zynq_ready_i,
  input  logic [CHAN-1:0]   rodone_ni,
  output logic [CHAN-1:0]   trigger_o,
  output logic [CHAN-1:0]   rd_request_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              zynq_rd_en_o,
  output logic              done_o,
  output logic [CHAN-1:0]   err_mask_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DELAY    = 3'd1,
    SELECT   = 3'd2,
    TRIG     = 3'd3,
    READ     = 3'd4,
    WAITDONE = 3'd5,
    FINISH   = 3'd6
  } state_e;

  state_e             state_q,    state_d;
  logic               eos_q;
  logic [CHAN-1:0]    pending_q,  pending_d;
  logic [SEL_W-1:0]   sel_q,      sel_d;
  logic [OFF_W-1:0]   dcnt_q,     dcnt_d;
  logic [CNT_W-1:0]   wcnt_q,     wcnt_d;
  logic [CNT_W-1:0]   how_many_q, how_many_d;
  logic [TCNT_W-1:0]  tcnt_q,     tcnt_d;
  logic [CHAN-1:0]    err_q,      err_d;

  logic               eos_rise;
  logic               read_ok;
  logic [SEL_W-1:0]   lowest_idx;

  // Start condition is a registered-compare rising edge, so a level held high
  // cannot retrigger a sequence.
  assign eos_rise = eos_i & ~eos_q;

  // A read strobe fires only while words remain and downstream is ready.
  assign read_ok = (state_q == READ) && zynq_ready_i && (wcnt_q != '0);

  // Lowest set bit of the pending mask; scanning downward lets the last
  // assignment win, which leaves the smallest index.
  always_comb begin
    lowest_idx = '0;
    for (int i = CHAN - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest_idx = SEL_W'(i);
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      eos_q      <= 1'b0;
      pending_q  <= '0;
      sel_q      <= '0;
      dcnt_q     <= '0;
      wcnt_q     <= '0;
      how_many_q <= '0;
      tcnt_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      eos_q      <= eos_i;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      dcnt_q     <= dcnt_d;
      wcnt_q     <= wcnt_d;
      how_many_q <= how_many_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    sel_d      = sel_q;
    dcnt_d     = dcnt_q;
    wcnt_d     = wcnt_q;
    how_many_d = how_many_q;
    tcnt_d     = tcnt_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (eos_rise) begin
          pending_d  = chan_en_i;
          how_many_d = how_many_i;
          err_d      = '0;
          dcnt_d     = offset_i;
          state_d    = (offset_i == '0) ? SELECT : DELAY;
        end
      end

      DELAY: begin
        // Leaving at dcnt==1 makes the stay exactly OFFSET cycles long.
        if (dcnt_q <= OFF_W'(1)) begin
          dcnt_d  = '0;
          state_d = SELECT;
        end else begin
          dcnt_d = dcnt_q - OFF_W'(1);
        end
      end

      SELECT: begin
        if (pending_q == '0) begin
          state_d = FINISH;
        end else begin
          sel_d   = lowest_idx;
          state_d = TRIG;
        end
      end

      TRIG: begin
        wcnt_d  = how_many_q;
        tcnt_d  = '0;
        state_d = (how_many_q == '0) ? WAITDONE : READ;
      end

      READ: begin
        if (read_ok) begin
          wcnt_d = wcnt_q - CNT_W'(1);
          if (wcnt_q == CNT_W'(1)) state_d = WAITDONE;
        end
      end

      WAITDONE: begin
        // A done seen on the same cycle as the timeout wins, so no error flag.
        if (!rodone_ni[sel_q]) begin
          pending_d[sel_q] = 1'b0;
          state_d          = SELECT;
        end else if (tcnt_q == TCNT_W'(TMO - 1)) begin
          err_d[sel_q]     = 1'b1;
          pending_d[sel_q] = 1'b0;
          state_d          = SELECT;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      FINISH: begin
        pending_d  = '0;
        how_many_d = '0;
        wcnt_d     = '0;
        tcnt_d     = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only (plus the live ready for
  // the read strobe), so an asynchronous reset clears them at once.
  always_comb begin
    trigger_o    = '0;
    rd_request_o = '0;
    zynq_rd_en_o = (state_q != IDLE);
    done_o       = (state_q == FINISH);
    if (state_q == TRIG || state_q == READ || state_q == WAITDONE) begin
      trigger_o[sel_q] = 1'b1;
    end
    if (read_ok) begin
      rd_request_o[sel_q] = 1'b1;
    end
  end

  assign sel_o      = sel_q;
  assign err_mask_o = err_q;

endmodule
